// File: rtl/mult_div_pkg.sv
// Shared definitions for the mult/div unit: sequencer state encoding,
// datapath widths and HI/LO split helpers used by the Divider and seq_multiplier.
package mult_div_pkg;

   // Sequencer states, shared encoding with the Divider
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_FIX  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   // Architectural operand width and the double-width HI/LO result
   localparam int MD_WIDTH  = 16;
   localparam int MD_RES_W  = 2 * MD_WIDTH;

   // Upper half of a product, destined for HI
   function automatic logic [MD_WIDTH-1:0] hi_part(input logic [MD_RES_W-1:0] v);
      return v[MD_RES_W-1:MD_WIDTH];
   endfunction

   // Lower half of a product, destined for LO
   function automatic logic [MD_WIDTH-1:0] lo_part(input logic [MD_RES_W-1:0] v);
      return v[MD_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/seq_multiplier_abs_neg.sv
// Conditional two's complement: passes din through, or negates it when neg is set.
// Used both for operand magnitudes and for restoring the product sign.
module abs_neg #(
   parameter int W = 16
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   // Negation is invert-and-increment; the most-negative value maps onto itself,
   // which read as unsigned is exactly its magnitude.
   always_comb begin
      dout = din;
      if (neg)
         dout = ~din + {{(W-1){1'b0}}, 1'b1};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU. Multiplies operand magnitudes
// one multiplicand bit per clock, then applies the sign in a single fix-up cycle.
// Latency from accepted start to validity is WIDTH+1 clocks regardless of data.
module seq_multiplier
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               validity,
   output logic [2*WIDTH-1:0] result
);

   localparam int             CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]         state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] mplier;
   logic [2*WIDTH-1:0] acc;
   logic               neg;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] fixed_prod;
   logic               accept;

   // Operand sign bits only matter for signed multiplication
   always_comb begin
      a_neg  = signed_op & multiplicand[WIDTH-1];
      b_neg  = signed_op & multiplier[WIDTH-1];
      accept = start & ((state == ST_IDLE) | (state == ST_DONE));
   end

   abs_neg #(.W(WIDTH)) u_abs_a (
      .neg  (a_neg),
      .din  (multiplicand),
      .dout (a_mag)
   );

   abs_neg #(.W(WIDTH)) u_abs_b (
      .neg  (b_neg),
      .din  (multiplier),
      .dout (b_mag)
   );

   abs_neg #(.W(2*WIDTH)) u_fix (
      .neg  (neg),
      .din  (acc),
      .dout (fixed_prod)
   );

   // Sequencer and shift-add datapath; reset clears everything, even mid-run
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  mcand  <= a_mag;
                  mplier <= {{WIDTH{1'b0}}, b_mag};
                  acc    <= '0;
                  count  <= '0;
                  neg    <= a_neg ^ b_neg;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Magnitudes never exceed 2^(WIDTH-1)... 2^WIDTH-1, so the
               // 2*WIDTH-bit accumulator cannot overflow.
               if (mcand[0])
                  acc <= acc + mplier;
               mplier <= mplier << 1;
               mcand  <= mcand >> 1;
               count  <= count + CNT_W'(1);
               if (count == LAST_STEP)
                  state <= ST_FIX;
            end
            ST_FIX: begin
               result <= fixed_prod;
               state  <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake flags are pure decodes of the state
   always_comb begin
      busy     = (state == ST_RUN) | (state == ST_FIX);
      validity = (state == ST_DONE);
   end

endmodule
